// File: rtl/mc_datapath_pkg.sv
// Shared encodings for the multi-cycle RV32I/RV64I datapath: ALU ops, operand and
// result selects, immediate formats and the memory-port FSM states.
package mc_datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'd0,
    RES_MDR    = 2'd1,
    RES_ALU    = 2'd2,
    RES_IMM    = 2'd3
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_A     = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_B    = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } src_b_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // 32-bit immediate; the datapath sign-extends it to XLEN.
  function automatic logic [31:0] imm_ext32(input logic [31:0] ir, input logic [2:0] sel);
    case (imm_src_e'(sel))
      IMM_I:   return {{20{ir[31]}}, ir[31:20]};
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      IMM_U:   return {ir[31:12], 12'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mc_mem_port.sv
// Unified memory port: valid/ack handshake FSM with address, write data, direction
// and instruction-fetch tag latched for the whole transaction.
module mc_mem_port
  import mc_datapath_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_req_i,
  input  logic            wr_req_i,
  input  logic            ir_wr_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            mem_ack_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            mem_busy_o,
  output logic            mem_done_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic            rd_ack_o,
  output logic            ir_load_o
);

  mem_state_e      state_q;
  logic            req_q, busy_q, done_q, we_q, tag_q;
  logic [XLEN-1:0] addr_q, wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      tag_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (rd_req_i || wr_req_i) begin
            // A simultaneous write wins and the read (and its fetch tag) is dropped.
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            we_q    <= wr_req_i;
            tag_q   <= rd_req_i && ir_wr_i && !wr_req_i;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_ack_i) begin
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= MEM_DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= MEM_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_busy_o  = busy_q;
  assign mem_done_o  = done_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rd_ack_o    = (state_q == MEM_REQ) && mem_ack_i && !we_q;
  assign ir_load_o   = rd_ack_o && tag_q;

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle RV32I/RV64I datapath: one ALU, staging registers (IR, OldPC, MDR, A, B,
// ALUOut), register file and a handshaked unified memory port, steered by an external FSM.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          NREGS    = 32,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_wr_i,
  input  logic            adr_src_i,
  input  logic            mem_rd_req_i,
  input  logic            mem_wr_req_i,
  input  logic            ir_wr_i,
  input  logic            reg_wr_i,
  input  logic [1:0]      alu_src_a_i,
  input  logic [1:0]      alu_src_b_i,
  input  logic [2:0]      alu_control_i,
  input  logic [2:0]      imm_src_i,
  input  logic [1:0]      result_src_i,
  output logic [6:0]      op_o,
  output logic [2:0]      func3_o,
  output logic [6:0]      func7_o,
  output logic            zero_o,
  output logic            alu_sign_o,
  output logic            mem_busy_o,
  output logic            mem_done_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ack_i
);

  localparam int RW  = $clog2(NREGS);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] pc_q, pc_d, old_pc_q, mdr_q, a_q, b_q, alu_out_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] imm, src_a, src_b, alu_result, result, rd1, rd2;
  logic [RW-1:0]   rs1, rs2, rd;
  logic            rd_ack, ir_load;

  assign rs1 = ir_q[15 +: RW];
  assign rs2 = ir_q[20 +: RW];
  assign rd  = ir_q[7 +: RW];
  // x0 is never written and resets to zero, so a plain read returns 0 for it.
  assign rd1 = regs_q[rs1];
  assign rd2 = regs_q[rs2];
  assign imm = XLEN'($signed(imm_ext32(ir_q, imm_src_i)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    src_a = '0;
    src_b = '0;
    case (src_a_e'(alu_src_a_i))
      SRCA_PC:    src_a = pc_q;
      SRCA_OLDPC: src_a = old_pc_q;
      SRCA_A:     src_a = a_q;
      default:    src_a = '0;
    endcase
    case (src_b_e'(alu_src_b_i))
      SRCB_B:    src_b = b_q;
      SRCB_IMM:  src_b = imm;
      SRCB_FOUR: src_b = XLEN'(4);
      default:   src_b = '0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(alu_control_i))
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = XLEN'($signed(src_a) < $signed(src_b));
      ALU_SLL: alu_result = src_a << src_b[SHW-1:0];
      ALU_SRL: alu_result = src_a >> src_b[SHW-1:0];
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    result = alu_out_q;
    case (result_src_e'(result_src_i))
      RES_ALUOUT: result = alu_out_q;
      RES_MDR:    result = mdr_q;
      RES_ALU:    result = alu_result;
      RES_IMM:    result = imm;
      default:    result = alu_out_q;
    endcase
  end

  assign pc_d = pc_wr_i ? result : pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC[XLEN-1:0];
      old_pc_q  <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      pc_q      <= pc_d;
      a_q       <= rd1;
      b_q       <= rd2;
      alu_out_q <= alu_result;
      if (rd_ack) mdr_q <= mem_rdata_i;
      if (ir_load) begin
        ir_q     <= mem_rdata_i[31:0];
        old_pc_q <= mem_addr_o;
      end
    end
  end

  // NOTE: the register file is reset explicitly because x0 relies on holding zero;
  // a reset-free array would leave it undefined and block RAM inference isn't needed here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (reg_wr_i && (rd != '0)) begin
      regs_q[rd] <= result;
    end
  end

  mc_mem_port #(.XLEN(XLEN)) u_mem_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req_i   (mem_rd_req_i),
    .wr_req_i   (mem_wr_req_i),
    .ir_wr_i    (ir_wr_i),
    .addr_i     (adr_src_i ? alu_out_q : pc_q),
    .wdata_i    (b_q),
    .mem_ack_i  (mem_ack_i),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_busy_o (mem_busy_o),
    .mem_done_o (mem_done_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .rd_ack_o   (rd_ack),
    .ir_load_o  (ir_load)
  );

  assign op_o       = ir_q[6:0];
  assign func3_o    = ir_q[14:12];
  assign func7_o    = ir_q[31:25];
  assign zero_o     = (alu_result == '0);
  assign alu_sign_o = alu_result[XLEN-1];

endmodule
